// File: rtl/adc_idelay_calibrator_if.sv
// Control and data bundle for the AD9284 IODELAY tap calibrator.
// Ports:
//   start        : one-cycle pulse that starts calibration of every lane
//   adc_data_p/n : IDDR Q1/Q2 sample per lane
//   delay_ld     : one-hot IODELAYE1 load strobe per lane
//   delay_wdata  : tap value shared by all IODELAYE1 CNTVALUEIN inputs
//   busy/done    : sweep in progress / completion pulse
//   lane_err     : per-lane flag, no passing window of sufficient width was found
//   lane_tap     : final tap per lane, lane i at [5i+4:5i]
interface adc_idelay_calibrator_if #(
   parameter int unsigned NUM_LANES = 8
);
   logic                   start;
   logic [NUM_LANES-1:0]   adc_data_p;
   logic [NUM_LANES-1:0]   adc_data_n;
   logic [NUM_LANES-1:0]   delay_ld;
   logic [4:0]             delay_wdata;
   logic                   busy;
   logic                   done;
   logic [NUM_LANES-1:0]   lane_err;
   logic [5*NUM_LANES-1:0] lane_tap;

   // Capture/control side: drives start and the sampled data
   modport master (
      output start, adc_data_p, adc_data_n,
      input  delay_ld, delay_wdata, busy, done, lane_err, lane_tap
   );

   // Calibrator side
   modport slave (
      input  start, adc_data_p, adc_data_n,
      output delay_ld, delay_wdata, busy, done, lane_err, lane_tap
   );
endinterface

// File: rtl/adc_idelay_calibrator.sv
// Per-lane IODELAYE1 tap sweep for the AD9284 LVDS capture path.
// For each lane, taps 0..31 are loaded in turn, the IDDR samples are compared
// against the ADC test pattern, and the centre of the longest contiguous
// passing window is loaded as the final tap.
// Ports:
//   clock_in : adc_dco_clk, all logic on the rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : calibrator side of adc_idelay_calibrator_if
module adc_idelay_calibrator #(
   parameter int unsigned          NUM_LANES      = 8,
   parameter int unsigned          SETTLE_CYCLES  = 8,
   parameter int unsigned          COMPARE_CYCLES = 64,
   parameter int unsigned          MIN_WINDOW     = 4,
   parameter logic [NUM_LANES-1:0] EXPECTED_P     = NUM_LANES'(8'hAA),
   parameter logic [NUM_LANES-1:0] EXPECTED_N     = NUM_LANES'(8'h55),
   parameter logic [4:0]           DEFAULT_TAP    = 5'd0
) (
   input  logic                    clock_in,
   input  logic                    reset_n,
   adc_idelay_calibrator_if.slave  bus
);

   localparam int unsigned TAP_W   = 5;
   localparam int unsigned LEN_W   = 6;
   localparam int unsigned LANE_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int unsigned CNT_MAX = (SETTLE_CYCLES > COMPARE_CYCLES) ? SETTLE_CYCLES : COMPARE_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      IDLE, LOAD, SETTLE, CHECK, EVAL, SET_CENTER, NEXT_LANE, FINISH
   } state_t;

   state_t                 state_q, state_d;
   logic [LANE_W-1:0]      lane_q, lane_d;
   logic [TAP_W-1:0]       tap_q, tap_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   pass_q, pass_d;
   logic [TAP_W-1:0]       cur_start_q, cur_start_d;
   logic [LEN_W-1:0]       cur_len_q, cur_len_d;
   logic [TAP_W-1:0]       best_start_q, best_start_d;
   logic [LEN_W-1:0]       best_len_q, best_len_d;
   logic [NUM_LANES-1:0]   delay_ld_q, delay_ld_d;
   logic [TAP_W-1:0]       delay_wdata_q, delay_wdata_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [NUM_LANES-1:0]   lane_err_q, lane_err_d;
   logic [5*NUM_LANES-1:0] lane_tap_q, lane_tap_d;
   logic                   window_ok;
   logic [TAP_W-1:0]       centre;

   // State register
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:       if (bus.start) state_d = LOAD;
         LOAD:       state_d = SETTLE;
         SETTLE:     if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = CHECK;
         CHECK:      if (cnt_q == CNT_W'(COMPARE_CYCLES - 1)) state_d = EVAL;
         EVAL:       state_d = (tap_q == TAP_W'(31)) ? SET_CENTER : LOAD;
         SET_CENTER: state_d = NEXT_LANE;
         NEXT_LANE:  state_d = (lane_q == LANE_W'(NUM_LANES - 1)) ? FINISH : LOAD;
         FINISH:     state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   // Datapath and output next values; outputs are registered against state_d
   // so each strobe is visible during the cycle of the state it belongs to.
   always_comb begin
      lane_d        = lane_q;
      tap_d         = tap_q;
      cnt_d         = cnt_q;
      pass_d        = pass_q;
      cur_start_d   = cur_start_q;
      cur_len_d     = cur_len_q;
      best_start_d  = best_start_q;
      best_len_d    = best_len_q;
      delay_ld_d    = '0;
      delay_wdata_d = delay_wdata_q;
      busy_d        = 1'b0;
      done_d        = 1'b0;
      lane_err_d    = lane_err_q;
      lane_tap_d    = lane_tap_q;
      window_ok     = 1'b0;
      centre        = DEFAULT_TAP;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               lane_err_d   = '0;
               lane_tap_d   = '0;
               lane_d       = '0;
               tap_d        = '0;
               cur_start_d  = '0;
               cur_len_d    = '0;
               best_start_d = '0;
               best_len_d   = '0;
            end
         end
         LOAD: begin
            cnt_d  = '0;
            pass_d = 1'b1;
         end
         SETTLE: begin
            cnt_d = (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) ? '0 : cnt_q + CNT_W'(1);
         end
         CHECK: begin
            cnt_d = cnt_q + CNT_W'(1);
            if ((bus.adc_data_p[lane_q] != EXPECTED_P[lane_q]) ||
                (bus.adc_data_n[lane_q] != EXPECTED_N[lane_q]))
               pass_d = 1'b0;
         end
         EVAL: begin
            // Strict greater-than keeps the earliest window on ties
            if (pass_q) begin
               if (cur_len_q == '0) cur_start_d = tap_q;
               cur_len_d = cur_len_q + LEN_W'(1);
               if (cur_len_d > best_len_q) begin
                  best_start_d = cur_start_d;
                  best_len_d   = cur_len_d;
               end
            end else begin
               cur_len_d = '0;
            end
            if (tap_q != TAP_W'(31)) tap_d = tap_q + TAP_W'(1);
         end
         NEXT_LANE: begin
            if (lane_q != LANE_W'(NUM_LANES - 1)) begin
               lane_d       = lane_q + LANE_W'(1);
               tap_d        = '0;
               cur_start_d  = '0;
               cur_len_d    = '0;
               best_start_d = '0;
               best_len_d   = '0;
            end
         end
         default: ;
      endcase

      // best_start + (best_len-1)/2 stays within 0..31 for any window inside 0..31
      window_ok = (best_len_d >= LEN_W'(MIN_WINDOW));
      if (window_ok)
         centre = best_start_d + TAP_W'((best_len_d - LEN_W'(1)) >> 1);

      busy_d = (state_d != IDLE) && (state_d != FINISH);
      done_d = (state_d == FINISH);

      if (state_d == LOAD) begin
         delay_ld_d[lane_d] = 1'b1;
         delay_wdata_d      = tap_d;
      end else if (state_d == SET_CENTER) begin
         delay_ld_d[lane_d]                        = 1'b1;
         delay_wdata_d                             = centre;
         lane_tap_d[int'(lane_d) * TAP_W +: TAP_W] = centre;
         if (!window_ok) lane_err_d[lane_d] = 1'b1;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         lane_q        <= '0;
         tap_q         <= '0;
         cnt_q         <= '0;
         pass_q        <= 1'b0;
         cur_start_q   <= '0;
         cur_len_q     <= '0;
         best_start_q  <= '0;
         best_len_q    <= '0;
         delay_ld_q    <= '0;
         delay_wdata_q <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         lane_err_q    <= '0;
         lane_tap_q    <= '0;
      end else begin
         lane_q        <= lane_d;
         tap_q         <= tap_d;
         cnt_q         <= cnt_d;
         pass_q        <= pass_d;
         cur_start_q   <= cur_start_d;
         cur_len_q     <= cur_len_d;
         best_start_q  <= best_start_d;
         best_len_q    <= best_len_d;
         delay_ld_q    <= delay_ld_d;
         delay_wdata_q <= delay_wdata_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         lane_err_q    <= lane_err_d;
         lane_tap_q    <= lane_tap_d;
      end
   end

   assign bus.delay_ld    = delay_ld_q;
   assign bus.delay_wdata = delay_wdata_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.lane_err    = lane_err_q;
   assign bus.lane_tap    = lane_tap_q;

endmodule

// File: tb/tb_adc_idelay_calibrator.sv
// Directed bench for adc_idelay_calibrator: a per-lane IODELAY/ADC model
// returns the test pattern only for taps inside each lane's pass mask.
`timescale 1ns/1ps
module tb_adc_idelay_calibrator;
   localparam int unsigned NL = 8;
   localparam logic [NL-1:0] EXP_P = 8'hAA;
   localparam logic [NL-1:0] EXP_N = 8'h55;
   localparam int unsigned RUN_CYCLES = 18960;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   adc_idelay_calibrator_if #(.NUM_LANES(NL)) bus ();

   adc_idelay_calibrator #(.NUM_LANES(NL)) dut (
      .clock_in (clk),
      .reset_n  (rst_n),
      .bus      (bus.slave)
   );

   logic [31:0] mask    [NL];
   logic [4:0]  cur_tap [NL];
   logic [4:0]  exp_tap [NL];
   int          since_ld0;
   bit          inject;
   int          busy_cnt;
   int          done_cnt;
   logic [4:0]  last_wd5;
   int          total;
   int          bad;

   // IODELAY + ADC model: taps latch on the load strobe, data follows the mask
   always @(negedge clk) begin
      for (int i = 0; i < NL; i++)
         if (bus.delay_ld[i]) cur_tap[i] = bus.delay_wdata;
      since_ld0 = bus.delay_ld[0] ? 0 : since_ld0 + 1;
      if (bus.delay_ld[5]) last_wd5 = bus.delay_wdata;
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cnt++;
      for (int i = 0; i < NL; i++) begin
         bus.adc_data_p[i] = mask[i][cur_tap[i]] ? EXP_P[i] : ~EXP_P[i];
         bus.adc_data_n[i] = mask[i][cur_tap[i]] ? EXP_N[i] : ~EXP_N[i];
      end
      // LOAD is cycle 0 here, so 72 is the last CHECK cycle (1 + 8 settle + 64 compare - 1)
      if (inject && cur_tap[0] == 5'd12 && since_ld0 == 72)
         bus.adc_data_n[0] = ~bus.adc_data_n[0];
   end

   function automatic logic [31:0] rng(input int lo, input int hi);
      logic [31:0] r;
      for (int k = 0; k < 32; k++) r[k] = (k >= lo && k <= hi);
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output bit seen);
      seen = 1'b0;
      for (int k = 0; k < limit; k++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit seen;
      int b0, d0;
      total     = 0;
      bad       = 0;
      inject    = 1'b0;
      since_ld0 = 0;
      busy_cnt  = 0;
      done_cnt  = 0;
      last_wd5  = 5'h1F;
      for (int i = 0; i < NL; i++) begin
         cur_tap[i] = 5'd0;
         mask[i]    = 32'd0;
      end
      rst_n     = 1'b0;
      bus.start = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_delay_ld",    64'(bus.delay_ld),    64'd0);
      check("rst_delay_wdata", 64'(bus.delay_wdata), 64'd0);
      check("rst_busy",        64'(bus.busy),        64'd0);
      check("rst_done",        64'(bus.done),        64'd0);
      check("rst_lane_err",    64'(bus.lane_err),    64'd0);
      check("rst_lane_tap",    64'(bus.lane_tap),    64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Run A: mixed lane patterns, injected glitch on lane 0, restart during busy
      mask[0] = rng(8, 20);
      mask[1] = rng(10, 20);
      mask[2] = 32'hFFFF_FFFF;
      mask[3] = rng(2, 4) | rng(20, 27);
      mask[4] = rng(10, 20);
      mask[5] = rng(7, 9);
      mask[6] = rng(0, 4) | rng(10, 14);
      mask[7] = 32'd0;
      exp_tap[0] = 5'd16; exp_tap[1] = 5'd15; exp_tap[2] = 5'd15; exp_tap[3] = 5'd23;
      exp_tap[4] = 5'd15; exp_tap[5] = 5'd0;  exp_tap[6] = 5'd2;  exp_tap[7] = 5'd0;
      inject = 1'b1;
      b0 = busy_cnt;
      d0 = done_cnt;
      pulse_start();
      check("busy_after_start", 64'(bus.busy), 64'd1);
      repeat (100) @(negedge clk);
      pulse_start();
      wait_done(20000, seen);
      check("runA_done_seen", 64'(seen), 64'd1);
      check("runA_busy_at_done", 64'(bus.busy), 64'd0);
      repeat (3) @(negedge clk);
      check("runA_busy_cycles", 64'(busy_cnt - b0), 64'(RUN_CYCLES));
      check("runA_done_pulses", 64'(done_cnt - d0), 64'd1);
      check("runA_done_low", 64'(bus.done), 64'd0);
      for (int i = 0; i < NL; i++)
         check($sformatf("runA_lane_tap%0d", i), 64'(bus.lane_tap[5*i +: 5]), 64'(exp_tap[i]));
      check("runA_lane_err", 64'(bus.lane_err), 64'hA0);
      check("runA_lane5_last_wdata", 64'(last_wd5), 64'd0);
      inject = 1'b0;

      // Reset in the middle of lane 2's first CHECK phase
      for (int i = 0; i < NL; i++) mask[i] = rng(10, 20);
      pulse_start();
      seen = 1'b0;
      for (int k = 0; k < 6000; k++) begin
         @(negedge clk);
         if (bus.delay_ld[2]) begin
            seen = 1'b1;
            break;
         end
      end
      check("lane2_load_seen", 64'(seen), 64'd1);
      repeat (20) @(negedge clk);
      check("mid_lane0_tap", 64'(bus.lane_tap[4:0]), 64'd15);
      check("mid_busy", 64'(bus.busy), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      check("arst_delay_ld",    64'(bus.delay_ld),    64'd0);
      check("arst_delay_wdata", 64'(bus.delay_wdata), 64'd0);
      check("arst_busy",        64'(bus.busy),        64'd0);
      check("arst_done",        64'(bus.done),        64'd0);
      check("arst_lane_err",    64'(bus.lane_err),    64'd0);
      check("arst_lane_tap",    64'(bus.lane_tap),    64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("post_rst_idle_busy", 64'(bus.busy), 64'd0);
      check("post_rst_idle_ld",   64'(bus.delay_ld), 64'd0);

      // Run B: clean recalibration from lane 0
      b0 = busy_cnt;
      d0 = done_cnt;
      pulse_start();
      wait_done(20000, seen);
      check("runB_done_seen", 64'(seen), 64'd1);
      repeat (3) @(negedge clk);
      check("runB_busy_cycles", 64'(busy_cnt - b0), 64'(RUN_CYCLES));
      check("runB_done_pulses", 64'(done_cnt - d0), 64'd1);
      check("runB_lane_tap", 64'(bus.lane_tap), 64'({8{5'd15}}));
      check("runB_lane_err", 64'(bus.lane_err), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/adc_idelay_calibrator.md
Name: adc_idelay_calibrator

Overview:
Calibrates input delay taps for the 8-lane AD9284 LVDS capture path.
- The ADC is set to a fixed test pattern. Per lane, the block sweeps the IODELAYE1 tap value 0..31 and checks the IDDR rising/falling samples against the expected pattern.
- It finds the longest contiguous passing tap window and loads the window centre.
- It runs in the adc_dco_clk domain, beside the IODELAYE1/IDDR generate loop, with IODELAYE1 in VAR_LOADABLE mode.

Parameters:
NUM_LANES, 8, number of data lanes calibrated.
SETTLE_CYCLES, 8, wait after a tap load before comparing (covers IODELAY+IDDR pipeline); min 2.
COMPARE_CYCLES, 64, consecutive sample cycles that must all match for a tap to pass; min 1.
MIN_WINDOW, 4, minimum passing-window width (taps) for a lane to be good; range 1..32.
EXPECTED_P, 8'hAA, expected IDDR Q1 bit per lane during the test pattern.
EXPECTED_N, 8'h55, expected IDDR Q2 bit per lane during the test pattern.
DEFAULT_TAP, 5'd0, tap loaded into a lane that fails calibration.

Ports:
clock_in  input  1  adc_dco_clk (BUFR output); all logic on rising edge.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  one-cycle pulse begins calibration of all lanes; ignored while busy=1.
adc_data_p  input  NUM_LANES  IDDR Q1 per lane.
adc_data_n  input  NUM_LANES  IDDR Q2 per lane.
delay_ld  output  NUM_LANES  one-hot load strobe to IODELAYE1 RST (LD) of the selected lane.
delay_wdata  output  5  tap value to IODELAYE1 CNTVALUEIN (shared by all lanes).
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle pulse when all lanes are finished.
lane_err  output  NUM_LANES  sticky per-lane flag: best window < MIN_WINDOW.
lane_tap  output  5*NUM_LANES  final tap per lane, lane i at [5i+4:5i].

Behaviour:
- Reset (async assert, sync release) clears all of the following to 0: delay_ld, delay_wdata, busy, done, lane_err, lane_tap, all counters and window registers. FSM goes to IDLE.
- Reset mid-sweep aborts the sweep and applies the same clears. IODELAY taps stay at their last loaded value; no cleanup load is issued.
- FSM states: IDLE, LOAD, SETTLE, CHECK, EVAL, SET_CENTER, NEXT_LANE, FINISH.
- IDLE: on start=1, clear lane_err and lane_tap, set lane=0, tap=0, clear window registers, go to LOAD. Start and busy are never high in the same decision cycle.
- LOAD (1 cycle): delay_ld[lane]=1, delay_wdata=tap. All other delay_ld bits are 0. delay_ld is high only in LOAD and SET_CENTER.
- SETTLE: wait exactly SETTLE_CYCLES cycles, then go to CHECK.
- CHECK: for COMPARE_CYCLES cycles, sample adc_data_p[lane] and adc_data_n[lane].
  - Pass flag starts at 1 and clears on any cycle where p != EXPECTED_P[lane] or n != EXPECTED_N[lane].
  - All mismatches are counted in the pass flag; there is no early exit.
- EVAL (1 cycle), window tracking:
  - Pass: if cur_len==0 then cur_start=tap. cur_len+=1. If new cur_len > best_len, set best_start=cur_start and best_len=new cur_len. A strict greater-than comparison means that on ties the earliest window wins.
  - Fail: cur_len=0.
  - cur_len and best_len are 6 bits (0..32).
  - If tap==31, go to SET_CENTER; otherwise tap+=1 and go to LOAD. The tap counter never wraps within a lane.
- SET_CENTER (1 cycle):
  - If best_len >= MIN_WINDOW: centre = best_start + ((best_len-1)>>1), computed in 6 bits, truncated to 5; the result never exceeds 31.
  - Otherwise: centre = DEFAULT_TAP and lane_err[lane]=1.
  - Assert delay_ld[lane]=1, delay_wdata=centre, and write lane_tap[lane]=centre.
- NEXT_LANE: if lane==NUM_LANES-1, go to FINISH. Otherwise lane+=1, tap=0, clear cur and best, go to LOAD.
- FINISH: done=1 for one cycle, busy=0 in the same cycle, return to IDLE. lane_tap and lane_err hold until the next accepted start or reset.
- Cycles per lane = 32*(1+SETTLE_CYCLES+COMPARE_CYCLES+1) + 2. With defaults: 32*74+2 = 2370 per lane, 18960 for 8 lanes, plus 1 cycle for FINISH.
- An all-pass lane gives best_start=0, best_len=32, centre=15. An all-fail lane gives best_len=0, error, DEFAULT_TAP.

Test Plan:
- Lane model passes taps 10..20 only, all lanes, defaults -> each lane_tap=15; lane_err=0; done pulses exactly once; busy high for 18960 cycles.
- Lane 3 passes taps 2..4 and 20..27; other lanes pass 0..31 -> lane_tap[3]=23; other lanes 15; lane_err=0.
- Lane 5 passes only taps 7..9 (MIN_WINDOW=4) -> lane_err=8'h20, lane_tap[5]=0, last delay_ld for lane 5 has delay_wdata=0.
- A single mismatch injected on adc_data_n[0] in the last CHECK cycle at tap 12, with pass window 8..20 -> tap 12 fails; windows 8..11 and 13..20; lane_tap[0]=16.
- Lane with two equal windows 0..4 and 10..14 -> earliest wins, lane_tap=2. Second start pulse during busy -> ignored, total cycle count unchanged.
- reset_n asserted mid-CHECK on lane 2 -> same cycle all outputs 0; after release, IDLE; a new start recalibrates from lane 0 with correct results.
